change_arbiter: RTL
===================

CHANGE_ARBITER -- requirements
Module: change_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored channels (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, width of each channel word.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_en  input  1  sample enable; channels are compared only when high.
REQ-006 i_data  input  NUM_CH*DATA_WIDTH  flattened channel words; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 o_valid  output  1  event available.
REQ-008 i_ready  input  1  consumer accepts the event.
REQ-009 o_ch  output  clog2(NUM_CH)  channel index of the presented event.
REQ-010 o_data  output  DATA_WIDTH  new value of that channel.
REQ-011 o_overrun  output  1  sticky flag: an unreported change was coalesced.

Function
REQ-012 Per channel: a shadow register, a pending bit and a latched value SHALL be kept.
REQ-013 When i_en=1 and word k != shadow k at an edge, then: shadow k <= word; latched k <= word; pending k <= 1.
REQ-014 When i_en=0, no shadow, pending or latched value SHALL change, except the clear defined in REQ-017.
REQ-015 FSM states: IDLE and PRESENT. IDLE -> PRESENT when any pending bit is set. PRESENT -> IDLE on a cycle with o_valid=1 and i_ready=1.
REQ-016 On entry to PRESENT:
- The granted channel is the first pending channel searched round-robin, starting at (last grant + 1) mod NUM_CH.
- o_ch and o_data SHALL be registered from that channel.
- o_valid SHALL be 1 throughout PRESENT.
REQ-017 The granted channel's pending bit SHALL be cleared on the grant edge. If the same edge also detects a new change on that channel, pending SHALL remain 1.
REQ-018 o_ch and o_data SHALL stay stable while o_valid=1 and i_ready=0.
REQ-019 Latency: a change detected at edge k gives o_valid=1 after edge k+1 when the FSM is IDLE.
REQ-020 Throughput: one event per two cycles maximum (the accept edge returns to IDLE; the next grant occurs on the following edge).
REQ-021 A change on a channel whose pending bit is already 1 SHALL overwrite the latched value (coalesce) and set o_overrun.
REQ-022 Equal words SHALL never create an event.
REQ-023 Last-grant pointer wrap: after channel NUM_CH-1 the search starts at 0.

Reset
REQ-024 Reset SHALL clear all shadows to 0, pending bits to 0, latched values to 0 and the last-grant pointer to NUM_CH-1, and SHALL force the FSM to IDLE.
REQ-025 Reset values: o_valid=0, o_ch=0, o_data=0, o_overrun=0.
REQ-026 Reset asserted mid-PRESENT SHALL drop the event without acceptance.
REQ-027 After reset, any nonzero word with i_en=1 counts as a change.

Configuration
REQ-028 Macro CHANGE_ARBITER_OVERRUN_EN defined: o_overrun behaves per REQ-021 and is cleared only by reset.
REQ-029 Macro undefined: the port is present but tied to 0, and no overrun logic is built.

Structure
REQ-030 The shared package change_pkg SHALL hold the FSM state typedef (ARB_IDLE, ARB_PRESENT) and the channel-index width function.
REQ-031 Per-channel shadow, pending and latched logic SHALL be the sub-module chg_slot, instantiated NUM_CH times in a generate loop.
REQ-032 The round-robin search SHALL be combinational within change_arbiter.

Verification
REQ-033 Reset, then i_en=1 with ch2=0x5A and others 0 -> after 2 edges: o_valid=1, o_ch=2, o_data=0x5A.
REQ-034 ch0 and ch3 change on the same edge, i_ready=1 -> events are reported ch0 then ch3; next simultaneous change on ch0 and ch3 -> ch3 is not first (ch0 is granted, search starts at 0 after ch3).
REQ-035 Hold i_ready=0 for 5 cycles while ch1 changes again -> o_ch/o_data stay stable; the second ch1 value appears as the next event.
REQ-036 Pending ch1 changes 0x11 -> 0x22 before grant, with the macro defined -> one event with o_data=0x22 and o_overrun=1; with the macro undefined -> o_overrun=0.
REQ-037 i_en=0 while the data toggles -> no events; assert i_rst during PRESENT -> o_valid=0 immediately, and no event appears afterwards for unchanged zero words.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types for the change arbiter: FSM state encoding and channel-index width.
// Latency: n/a (package).
// Backpressure: n/a (package).
package change_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_e;

    // Width of a channel index; never below one bit so a 1-channel slice still elaborates.
    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chg_slot.sv
// One monitored channel: shadow of the last seen word, pending flag and the value to report.
// Latency: a differing word sets pending on the same edge it is sampled.
// Backpressure: none; a new change while pending overwrites the latched value (coalesce).
module chg_slot #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_clr,
    output logic                  o_pending,
`ifdef CHANGE_ARBITER_OVERRUN_EN
    output logic                  o_coalesce,
`endif
    output logic [DATA_WIDTH-1:0] o_latched
);

    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] latched_q;
    logic                  pending_q;
    logic                  change;

    assign change = i_en && (i_word != shadow_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q  <= '0;
            latched_q <= '0;
            pending_q <= 1'b0;
        end else begin
            if (change) begin
                shadow_q  <= i_word;
                latched_q <= i_word;
            end
            // A change on the grant edge wins over the clear so that value is not lost.
            if (change) begin
                pending_q <= 1'b1;
            end else if (i_clr) begin
                pending_q <= 1'b0;
            end
        end
    end

`ifdef CHANGE_ARBITER_OVERRUN_EN
    // On the grant edge the old value is being reported, so nothing is actually lost.
    assign o_coalesce = change && pending_q && !i_clr;
`endif

    assign o_pending = pending_q;
    assign o_latched = latched_q;

endmodule

// File: rtl/change_arbiter.sv
// Watches NUM_CH words and reports each change as (channel, value) round-robin; optional CHANGE_ARBITER_OVERRUN_EN.
// Latency: change sampled at edge k is presented after edge k+1; one event per two cycles at most.
// Backpressure: o_ch/o_data hold while i_ready=0; further changes coalesce in their slot.
module change_arbiter
    import change_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int CW         = ch_w(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CW-1:0]                o_ch,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_overrun
);

    arb_state_e            state_q, state_d;
    logic [CW-1:0]         last_q, last_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     clr;
    logic [DATA_WIDTH-1:0] latched [NUM_CH];
`ifdef CHANGE_ARBITER_OVERRUN_EN
    logic [NUM_CH-1:0]     coal;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        chg_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_en),
            .i_word    (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_clr     (clr[k]),
            .o_pending (pend[k]),
`ifdef CHANGE_ARBITER_OVERRUN_EN
            .o_coalesce(coal[k]),
`endif
            .o_latched (latched[k])
        );
    end

    // Round-robin search: first pending channel starting one past the last grant.
    logic [CW-1:0] grant;
    logic [CW-1:0] idx;
    logic          found;

    always_comb begin
        grant = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(last_q) + i) % NUM_CH);
            if (!found && pend[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ch_d    = ch_q;
        data_d  = data_q;
        clr     = '0;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d    = ARB_PRESENT;
                    last_d     = grant;
                    ch_d       = grant;
                    data_d     = latched[grant];
                    clr[grant] = 1'b1;
                end
            end
            ARB_PRESENT: begin
                if (i_ready) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ARB_IDLE;
            last_q  <= CW'(NUM_CH - 1);
            ch_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = (state_q == ARB_PRESENT);
    assign o_ch    = ch_q;
    assign o_data  = data_q;

`ifdef CHANGE_ARBITER_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovr_q <= 1'b0;
        end else if (|coal) begin
            ovr_q <= 1'b1;
        end
    end

    assign o_overrun = ovr_q;
`else
    assign o_overrun = 1'b0;
`endif

endmodule
